fp_norm_round: RTL and testbench



---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_norm_round_if.sv | 28 ++
 rtl/fp_round_rne.sv | 18 +
 rtl/fp_norm_round.sv | 107 ++++++++++
 tb/tb_fp_norm_round.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared constants, field widths and packing helper for the binary32 multiplier datapath.
package fp_pkg;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned PROD_W  = 48;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  // Stage-1 payload: normalized fraction plus guard/sticky, exponent already unbiased.
  typedef struct packed {
    logic                    sign;
    logic                    zero;
    logic signed [EXP_W+1:0] e;
    logic [FRAC_W-1:0]       frac;
    logic                    g;
    logic                    s;
  } s1_t;

  function automatic logic [31:0] pack(input logic sign, input logic [EXP_W-1:0] expo,
                                       input logic [FRAC_W-1:0] frac);
    return {sign, expo, frac};
  endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Upstream/downstream valid-ready bundle for the normalize/round stage.
interface fp_norm_round_if;
  import fp_pkg::*;

  logic                valid_in;
  logic                ready_in;
  logic [EXP_W:0]      Exp_resul;
  logic [PROD_W-1:0]   Mant_prod;
  logic                Signo;
  logic                Es_cero;
  logic                valid_out;
  logic                ready_out;
  logic [31:0]         Resultado;
  logic                Overflow;
  logic                Underflow;
  logic                Inexact;

  // master: the environment driving operands and sinking results
  modport master (
    output valid_in, Exp_resul, Mant_prod, Signo, Es_cero, ready_out,
    input  ready_in, valid_out, Resultado, Overflow, Underflow, Inexact
  );

  modport slave (
    input  valid_in, Exp_resul, Mant_prod, Signo, Es_cero, ready_out,
    output ready_in, valid_out, Resultado, Overflow, Underflow, Inexact
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard and sticky bits.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              g_i,
  input  logic              s_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o
);

  logic round_up;

  assign round_up = g_i & (s_i | frac_i[0]);
  // Carry out means 1.111..1 rounded to 10.0: fraction wraps to zero, exponent must bump.
  assign {carry_o, frac_o} = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize / round-and-pack pipeline for the binary32 multiplier, valid/ready.
module fp_norm_round #(
  parameter int unsigned BIAS = fp_pkg::BIAS
) (
  input logic            clk,
  input logic            rst,
  fp_norm_round_if.slave bus
);
  import fp_pkg::*;

  logic adv1, adv2;
  logic v1_q, v2_q;
  s1_t  s1_d, s1_q;

  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q;
  logic        unf_d, unf_q;
  logic        inx_d, inx_q;

  logic [FRAC_W-1:0]       frac_rnd;
  logic                    carry;
  logic signed [EXP_W+1:0] e_raw;
  logic signed [EXP_W+1:0] e_rnd;

  // A stage may load when it is empty or its contents move on this edge.
  assign adv2         = !v2_q | bus.ready_out;
  assign adv1         = !v1_q | adv2;
  assign bus.ready_in = adv1;

  assign e_raw = $signed({1'b0, bus.Exp_resul}) - $signed(10'(BIAS));

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.Signo;
    s1_d.zero = bus.Es_cero;
    if (bus.Mant_prod[47]) begin
      s1_d.e    = e_raw + 10'sd1;
      s1_d.frac = bus.Mant_prod[46:24];
      s1_d.g    = bus.Mant_prod[23];
      s1_d.s    = |bus.Mant_prod[22:0];
    end else begin
      s1_d.e    = e_raw;
      s1_d.frac = bus.Mant_prod[45:23];
      s1_d.g    = bus.Mant_prod[22];
      s1_d.s    = |bus.Mant_prod[21:0];
    end
  end

  fp_round_rne u_round (
    .frac_i  (s1_q.frac),
    .g_i     (s1_q.g),
    .s_i     (s1_q.s),
    .frac_o  (frac_rnd),
    .carry_o (carry)
  );

  assign e_rnd = s1_q.e + $signed({9'd0, carry});

  always_comb begin
    res_d = pack(s1_q.sign, e_rnd[EXP_W-1:0], frac_rnd);
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_q.g | s1_q.s;
    if (s1_q.zero) begin
      res_d = {s1_q.sign, 31'b0};
      inx_d = 1'b0;
    end else if (e_rnd >= $signed(10'(EXP_MAX))) begin
      res_d = pack(s1_q.sign, 8'hFF, '0);
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      res_d = {s1_q.sign, 31'b0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= bus.valid_in;
      if (adv1 && bus.valid_in) s1_q <= s1_d;
      if (adv2) v2_q <= v1_q;
      // Output data only moves when stage 2 takes a new item, so it holds under backpressure.
      if (adv2 && v1_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
      end
    end
  end

  assign bus.valid_out = v2_q;
  assign bus.Resultado = res_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.Inexact   = inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round: results, flags, backpressure and reset flush.
module tb_fp_norm_round;

  typedef struct {
    string       tag;
    logic [8:0]  expo;
    logic [47:0] mant;
    logic        sign;
    logic        zero;
    logic [31:0] res;
    logic [2:0]  flags;  // {Overflow, Underflow, Inexact}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[8];

  fp_norm_round_if bus ();

  fp_norm_round #(.BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.valid_in  = 1'b1;
    bus.Exp_resul = v.expo;
    bus.Mant_prod = v.mant;
    bus.Signo     = v.sign;
    bus.Es_cero   = v.zero;
  endtask

  task automatic idle();
    bus.valid_in  = 1'b0;
    bus.Exp_resul = '0;
    bus.Mant_prod = '0;
    bus.Signo     = 1'b0;
    bus.Es_cero   = 1'b0;
  endtask

  task automatic check_out(input vec_t v);
    check_eq({v.tag, ".valid"}, {31'd0, bus.valid_out}, 32'd1);
    check_eq({v.tag, ".res"}, bus.Resultado, v.res);
    check_eq({v.tag, ".flags"}, {29'd0, bus.Overflow, bus.Underflow, bus.Inexact},
             {29'd0, v.flags});
  endtask

  // Fixed latency: offered in cycle 0, valid_out visible in cycle 2.
  task automatic run_vec(input vec_t v);
    drive(v);
    check_eq({v.tag, ".ready_in"}, {31'd0, bus.ready_in}, 32'd1);
    step();
    idle();
    check_eq({v.tag, ".early"}, {31'd0, bus.valid_out}, 32'd0);
    step();
    check_out(v);
    step();
  endtask

  initial begin
    vecs[0] = '{"basic",   9'd255,  48'h6000_0000_0000, 1'b0, 1'b0, 32'h4040_0000, 3'b000};
    vecs[1] = '{"shift",   9'd254,  48'hFFFF_FE00_0001, 1'b0, 1'b0, 32'h407F_FFFE, 3'b001};
    vecs[2] = '{"tie_up",  9'd254,  48'h4000_00C0_0000, 1'b0, 1'b0, 32'h3F80_0002, 3'b001};
    vecs[3] = '{"tie_dn",  9'd254,  48'h4000_0040_0000, 1'b0, 1'b0, 32'h3F80_0000, 3'b001};
    vecs[4] = '{"carry",   9'd254,  48'h7FFF_FFC0_0000, 1'b0, 1'b0, 32'h4000_0000, 3'b001};
    vecs[5] = '{"ovf",     9'h1FC,  48'h8000_0000_0000, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};
    vecs[6] = '{"unf",     9'd100,  48'h4000_0000_0000, 1'b1, 1'b0, 32'h8000_0000, 3'b011};
    vecs[7] = '{"zero",    9'd200,  48'h0000_0000_0000, 1'b1, 1'b1, 32'h8000_0000, 3'b000};

    idle();
    bus.ready_out = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst.valid_out", {31'd0, bus.valid_out}, 32'd0);
    check_eq("rst.res", bus.Resultado, 32'd0);
    check_eq("rst.flags", {29'd0, bus.Overflow, bus.Underflow, bus.Inexact}, 32'd0);
    check_eq("rst.ready_in", {31'd0, bus.ready_in}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: two slots fill, the third offer stalls until the sink frees up.
    bus.ready_out = 1'b0;
    drive(vecs[0]);
    check_eq("bp.acc0", {31'd0, bus.ready_in}, 32'd1);
    step();
    drive(vecs[1]);
    check_eq("bp.acc1", {31'd0, bus.ready_in}, 32'd1);
    step();
    drive(vecs[2]);
    check_eq("bp.stall", {31'd0, bus.ready_in}, 32'd0);
    check_out(vecs[0]);
    step();
    check_eq("bp.stall2", {31'd0, bus.ready_in}, 32'd0);
    check_out(vecs[0]);
    bus.ready_out = 1'b1;
    #1;
    check_eq("bp.release", {31'd0, bus.ready_in}, 32'd1);
    step();
    idle();
    check_out(vecs[1]);
    step();
    check_out(vecs[2]);
    step();
    check_eq("bp.drained", {31'd0, bus.valid_out}, 32'd0);

    // Reset with both stages occupied must drop everything.
    bus.ready_out = 1'b0;
    drive(vecs[3]);
    step();
    drive(vecs[4]);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.ready_out = 1'b1;
    check_eq("mrst.valid_out", {31'd0, bus.valid_out}, 32'd0);
    check_eq("mrst.res", bus.Resultado, 32'd0);
    check_eq("mrst.ready_in", {31'd0, bus.ready_in}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("mrst.stale", {31'd0, bus.valid_out}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
